// File: rtl/lpc_reg_pkg.sv
// Shared types and constants for the LPC configuration/status register bank.
package lpc_reg_pkg;

    localparam int unsigned REG_W = 8;

    // Two-byte key sequence written to KEY_ADDR to open the write lock
    localparam logic [7:0] LPC_KEY1 = 8'h5A;
    localparam logic [7:0] LPC_KEY2 = 8'hA5;

    typedef enum logic [1:0] {
        StLocked,
        StKey1,
        StUnlocked
    } lockStateT;

    // Timer must hold tmo-1; never narrower than one bit
    function automatic int unsigned tmrWidth(input int unsigned tmo);
        return (tmo <= 2) ? 1 : $clog2(tmo);
    endfunction

endpackage

// File: rtl/lpc_reg_lock.sv
// Key-sequence write lock with inactivity timeout for the LPC register bank.
// Only instantiated when LPC_REG_LOCK_EN is defined.
module lpc_reg_lock
    import lpc_reg_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 32,
    parameter logic [7:0]  KEY_ADDR   = 8'hFF,
    parameter int unsigned UNLOCK_TMO = 1024
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       Wr,
    input  logic [7:0] Addr,
    input  logic [7:0] DataWrSW,
    output logic       Unlocked
);

    localparam int unsigned     TmrW    = tmrWidth(UNLOCK_TMO);
    localparam logic [TmrW-1:0] TmrLoad = TmrW'(UNLOCK_TMO - 1);

    lockStateT       lockState;
    logic [TmrW-1:0] timer;
    logic            keyWr;
    logic            regWr;

    assign keyWr = Wr && (Addr == KEY_ADDR);
    // While unlocked every in-range write is accepted, so it counts as activity
    assign regWr = Wr && (32'(Addr) < NUM_REGS);

    // Lock FSM and inactivity timer; Unlocked is a registered output
    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            lockState <= StLocked;
            timer     <= '0;
            Unlocked  <= 1'b0;
        end else begin
            unique case (lockState)
                StLocked: begin
                    if (keyWr && (DataWrSW == LPC_KEY1)) begin
                        lockState <= StKey1;
                        timer     <= TmrLoad;
                    end
                end
                StKey1: begin
                    if (Wr) begin
                        if (keyWr && (DataWrSW == LPC_KEY2)) begin
                            lockState <= StUnlocked;
                            timer     <= TmrLoad;
                            Unlocked  <= 1'b1;
                        end else begin
                            // Broken sequence: abandon the unlock attempt
                            lockState <= StLocked;
                            timer     <= '0;
                        end
                    end else if (timer == '0) begin
                        lockState <= StLocked;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                StUnlocked: begin
                    if (keyWr) begin
                        lockState <= StLocked;
                        timer     <= '0;
                        Unlocked  <= 1'b0;
                    end else if (regWr) begin
                        timer <= TmrLoad;
                    end else if (timer == '0) begin
                        lockState <= StLocked;
                        Unlocked  <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    lockState <= StLocked;
                    timer     <= '0;
                    Unlocked  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lpc_reg_bank.sv
// LPC-side configuration/status register bank with per-bit RW / HW / W1C typing.
// Define LPC_REG_LOCK_EN to build the key-sequence write lock for LOCK_MASK registers.
module lpc_reg_bank
    import lpc_reg_pkg::*;
#(
    parameter int unsigned                  NUM_REGS   = 32,
    parameter logic [NUM_REGS*REG_W-1:0]    RESET_VAL  = '0,
    parameter logic [NUM_REGS*REG_W-1:0]    WR_MASK    = {NUM_REGS{8'hFF}},
    parameter logic [NUM_REGS*REG_W-1:0]    HW_MASK    = '0,
    parameter logic [NUM_REGS*REG_W-1:0]    W1C_MASK   = '0,
    parameter logic [NUM_REGS-1:0]          LOCK_MASK  = '0,
    parameter logic [7:0]                   KEY_ADDR   = 8'hFF,
    parameter int unsigned                  UNLOCK_TMO = 1024
) (
    input  logic                      LpcClock,
    input  logic                      PciReset,
    input  logic [7:0]                Addr,
    input  logic                      Wr,
    input  logic [7:0]                DataWrSW,
    input  logic [NUM_REGS*REG_W-1:0] HwData,
    input  logic [NUM_REGS*REG_W-1:0] HwSet,
    output logic [7:0]                DataRd,
    output logic [NUM_REGS*REG_W-1:0] RegOut,
    output logic [NUM_REGS-1:0]       WrPulse,
    output logic                      Unlocked
);

    logic unlockedInt;

`ifdef LPC_REG_LOCK_EN
    localparam logic [NUM_REGS-1:0] LockMask = LOCK_MASK;

    lpc_reg_lock #(
        .NUM_REGS   (NUM_REGS),
        .KEY_ADDR   (KEY_ADDR),
        .UNLOCK_TMO (UNLOCK_TMO)
    ) uLock (
        .LpcClock (LpcClock),
        .PciReset (PciReset),
        .Wr       (Wr),
        .Addr     (Addr),
        .DataWrSW (DataWrSW),
        .Unlocked (unlockedInt)
    );
`else
    // No lock hardware: every register is always writable
    localparam logic [NUM_REGS-1:0] LockMask = '0;

    assign unlockedInt = 1'b1;

    logic unusedLockParams;
    assign unusedLockParams = ^{LOCK_MASK, KEY_ADDR, UNLOCK_TMO[0]};
`endif

    assign Unlocked = unlockedInt;

    for (genvar n = 0; n < NUM_REGS; n++) begin : gReg
        // Precedence HW > W1C > RW; bits in no mask are read-only
        localparam logic [REG_W-1:0] HwM  = HW_MASK[n*REG_W +: REG_W];
        localparam logic [REG_W-1:0] WrM  = WR_MASK[n*REG_W +: REG_W];
        localparam logic [REG_W-1:0] W1cM = W1C_MASK[n*REG_W +: REG_W] & ~HwM;
        localparam logic [REG_W-1:0] RwM  = WrM & ~HwM & ~W1C_MASK[n*REG_W +: REG_W];
        localparam logic [REG_W-1:0] RoM  = ~(HwM | W1C_MASK[n*REG_W +: REG_W] | WrM);

        logic             sel;
        logic [REG_W-1:0] cur;
        logic [REG_W-1:0] nxt;
        logic [REG_W-1:0] swClr;
        logic             pulseQ;

        assign sel   = Wr && (Addr == 8'(n)) && (!LockMask[n] || unlockedInt);
        assign swClr = sel ? (DataWrSW & WrM) : '0;

        // W1C: set pulse wins over a simultaneous software clear
        assign nxt = (HwM  & HwData[n*REG_W +: REG_W])
                   | (W1cM & ((cur & ~swClr) | HwSet[n*REG_W +: REG_W]))
                   | (RwM  & (sel ? DataWrSW : cur))
                   | (RoM  & cur);

        // Register contents and one-cycle write strobe per accepted write
        always_ff @(posedge LpcClock or negedge PciReset) begin
            if (!PciReset) begin
                cur    <= RESET_VAL[n*REG_W +: REG_W];
                pulseQ <= 1'b0;
            end else begin
                cur    <= nxt;
                pulseQ <= sel;
            end
        end

        assign RegOut[n*REG_W +: REG_W] = cur;
        assign WrPulse[n]               = pulseQ;
    end

    // Combinational read mux: register space, then lock status at KEY_ADDR
    always_comb begin
        DataRd = '0;
        for (int unsigned n = 0; n < NUM_REGS; n++) begin
            if (Addr == 8'(n)) begin
                DataRd = RegOut[n*REG_W +: REG_W];
            end
        end
`ifdef LPC_REG_LOCK_EN
        if (Addr == KEY_ADDR) begin
            DataRd = {7'b0, unlockedInt};
        end
`endif
    end

endmodule

// File: tb/tb_lpc_reg_bank.sv
// Self-checking bench for lpc_reg_bank; lock scenarios follow LPC_REG_LOCK_EN.
module tb_lpc_reg_bank;

    localparam int unsigned N      = 32;
    localparam logic [255:0] ResetVal = 256'h55 << 8;
    localparam logic [255:0] WrMask   = ~(256'hFF << 32) | (256'h1B << 32);
    localparam logic [255:0] HwMask   = 256'hF0 << 40;
    localparam logic [255:0] W1cMask  = 256'h01 << 16;
    localparam logic [31:0]  LockMask = 32'h0000_0100;

    logic           LpcClock = 1'b0;
    logic           PciReset;
    logic [7:0]     Addr;
    logic           Wr;
    logic [7:0]     DataWrSW;
    logic [255:0]   HwData;
    logic [255:0]   HwSet;
    logic [7:0]     DataRd;
    logic [255:0]   RegOut;
    logic [31:0]    WrPulse;
    logic           Unlocked;

    typedef struct {
        string      name;
        int         addr;
        logic [7:0] data;
        logic       pulse;
    } expT;

    expT sb[$];
    expT e;
    int  checks = 0;
    int  errors = 0;

    lpc_reg_bank #(
        .NUM_REGS   (N),
        .RESET_VAL  (ResetVal),
        .WR_MASK    (WrMask),
        .HW_MASK    (HwMask),
        .W1C_MASK   (W1cMask),
        .LOCK_MASK  (LockMask),
        .KEY_ADDR   (8'hFF),
        .UNLOCK_TMO (16)
    ) dut (
        .LpcClock (LpcClock),
        .PciReset (PciReset),
        .Addr     (Addr),
        .Wr       (Wr),
        .DataWrSW (DataWrSW),
        .HwData   (HwData),
        .HwSet    (HwSet),
        .DataRd   (DataRd),
        .RegOut   (RegOut),
        .WrPulse  (WrPulse),
        .Unlocked (Unlocked)
    );

    always #15 LpcClock = ~LpcClock;

    task automatic tick();
        @(posedge LpcClock);
        #1;
    endtask

    task automatic doWrite(input logic [7:0] a, input logic [7:0] d);
        Addr     = a;
        DataWrSW = d;
        Wr       = 1'b1;
        tick();
        Wr       = 1'b0;
    endtask

    task automatic test_reset();
        PciReset = 1'b0;
        Addr = 8'd1; Wr = 1'b0; DataWrSW = '0; HwData = '0; HwSet = '0;
        tick(); tick();
        checks++;
        if (DataRd !== 8'h55) begin
            errors++; $display("FAIL reset_reg1: got %h want 55", DataRd);
        end
        checks++;
        if (WrPulse !== 32'd0) begin
            errors++; $display("FAIL reset_pulse: got %h want 0", WrPulse);
        end
`ifdef LPC_REG_LOCK_EN
        checks++;
        if (Unlocked !== 1'b0) begin
            errors++; $display("FAIL reset_unlocked: got %b want 0", Unlocked);
        end
`else
        checks++;
        if (Unlocked !== 1'b1) begin
            errors++; $display("FAIL reset_unlocked: got %b want 1", Unlocked);
        end
`endif
        Addr = 8'hFF; #1;
        checks++;
        if (DataRd !== 8'h00) begin
            errors++; $display("FAIL reset_keyaddr: got %h want 00", DataRd);
        end
        PciReset = 1'b1;
        tick();
    endtask

    task automatic test_wr_mask();
        sb.push_back('{"wrmask_reg4", 4, 8'h1B, 1'b1});
        doWrite(8'd4, 8'hFF);
        e = sb.pop_front();
        checks++;
        if (RegOut[e.addr*8 +: 8] !== e.data) begin
            errors++; $display("FAIL %s: got %h want %h", e.name, RegOut[e.addr*8 +: 8], e.data);
        end
        checks++;
        if (WrPulse !== (e.pulse ? (32'd1 << e.addr) : 32'd0)) begin
            errors++; $display("FAIL %s_pulse: got %h want bit %0d", e.name, WrPulse, e.addr);
        end
        tick();
        checks++;
        if (WrPulse !== 32'd0) begin
            errors++; $display("FAIL wrmask_pulse_len: got %h want 0", WrPulse);
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{"b2b_reg6", 6, 8'h11, 1'b1});
        sb.push_back('{"b2b_reg7", 7, 8'h22, 1'b1});
        Wr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            Addr = 8'(6 + i);
            DataWrSW = (i == 0) ? 8'h11 : 8'h22;
            tick();
            e = sb.pop_front();
            checks++;
            if (RegOut[e.addr*8 +: 8] !== e.data || WrPulse !== (32'd1 << e.addr)) begin
                errors++;
                $display("FAIL %s: reg %h pulse %h want reg %h pulse bit %0d",
                         e.name, RegOut[e.addr*8 +: 8], WrPulse, e.data, e.addr);
            end
        end
        Wr = 1'b0;
        tick();
        checks++;
        if (WrPulse !== 32'd0) begin
            errors++; $display("FAIL b2b_pulse_end: got %h want 0", WrPulse);
        end
    endtask

    task automatic test_w1c();
        HwSet[16] = 1'b1;
        tick();
        HwSet[16] = 1'b0;
        checks++;
        if (RegOut[23:16] !== 8'h01) begin
            errors++; $display("FAIL w1c_set: got %h want 01", RegOut[23:16]);
        end
        // Clear and set in the same cycle: set wins
        sb.push_back('{"w1c_setwins", 2, 8'h01, 1'b1});
        sb.push_back('{"w1c_clear", 2, 8'h00, 1'b1});
        for (int i = 0; i < 2; i++) begin
            HwSet[16] = (i == 0);
            doWrite(8'd2, 8'h01);
            HwSet[16] = 1'b0;
            e = sb.pop_front();
            checks++;
            if (RegOut[e.addr*8 +: 8] !== e.data || WrPulse !== (32'd1 << e.addr)) begin
                errors++;
                $display("FAIL %s: reg %h pulse %h want reg %h pulse bit %0d",
                         e.name, RegOut[e.addr*8 +: 8], WrPulse, e.data, e.addr);
            end
        end
    endtask

    task automatic test_hw();
        HwData[47:40] = 8'hA7;
        tick();
        checks++;
        if (RegOut[47:40] !== 8'hA0) begin
            errors++; $display("FAIL hw_load: got %h want A0", RegOut[47:40]);
        end
        doWrite(8'd5, 8'h3C);
        checks++;
        if (RegOut[47:40] !== 8'hAC) begin
            errors++; $display("FAIL hw_mixed_write: got %h want AC", RegOut[47:40]);
        end
        HwData[47:40] = 8'h51;
        tick();
        checks++;
        if (RegOut[47:40] !== 8'h5C) begin
            errors++; $display("FAIL hw_follow: got %h want 5C", RegOut[47:40]);
        end
    endtask

    task automatic test_lock();
`ifdef LPC_REG_LOCK_EN
        sb.push_back('{"lock_reject", 8, 8'h00, 1'b0});
        sb.push_back('{"lock_accept", 8, 8'hAA, 1'b1});
        doWrite(8'd8, 8'hAA);
        e = sb.pop_front();
        checks++;
        if (RegOut[e.addr*8 +: 8] !== e.data || WrPulse !== 32'd0) begin
            errors++; $display("FAIL %s: reg %h pulse %h want reg %h pulse 0",
                               e.name, RegOut[e.addr*8 +: 8], WrPulse, e.data);
        end
        doWrite(8'hFF, 8'h5A);
        doWrite(8'hFF, 8'hA5);
        checks++;
        if (Unlocked !== 1'b1 || WrPulse !== 32'd0) begin
            errors++; $display("FAIL lock_unlock: unlocked %b pulse %h want 1/0", Unlocked, WrPulse);
        end
        doWrite(8'd8, 8'hAA);
        e = sb.pop_front();
        checks++;
        if (RegOut[e.addr*8 +: 8] !== e.data || WrPulse !== (32'd1 << e.addr)) begin
            errors++; $display("FAIL %s: reg %h pulse %h want reg %h pulse bit %0d",
                               e.name, RegOut[e.addr*8 +: 8], WrPulse, e.data, e.addr);
        end
        Addr = 8'hFF; #1;
        checks++;
        if (DataRd !== 8'h01) begin
            errors++; $display("FAIL lock_keyread: got %h want 01", DataRd);
        end
`else
        doWrite(8'd8, 8'hAA);
        checks++;
        if (RegOut[71:64] !== 8'hAA || WrPulse !== 32'h100 || Unlocked !== 1'b1) begin
            errors++; $display("FAIL nolock_write: reg %h pulse %h unl %b want AA/100/1",
                               RegOut[71:64], WrPulse, Unlocked);
        end
        doWrite(8'hFF, 8'h5A);
        Addr = 8'hFF; #1;
        checks++;
        if (DataRd !== 8'h00 || WrPulse !== 32'd0) begin
            errors++; $display("FAIL nolock_keyaddr: rd %h pulse %h want 00/0", DataRd, WrPulse);
        end
`endif
    endtask

    task automatic test_timeout();
`ifdef LPC_REG_LOCK_EN
        // Unlocked since the reg8 write; timer now at 15
        repeat (15) tick();
        checks++;
        if (Unlocked !== 1'b1) begin
            errors++; $display("FAIL tmo_before: got %b want 1", Unlocked);
        end
        // Write in the expiry cycle is accepted and keeps the lock open
        doWrite(8'd8, 8'h33);
        checks++;
        if (RegOut[71:64] !== 8'h33 || Unlocked !== 1'b1) begin
            errors++; $display("FAIL tmo_lastwrite: reg %h unl %b want 33/1", RegOut[71:64], Unlocked);
        end
        repeat (15) tick();
        checks++;
        if (Unlocked !== 1'b1) begin
            errors++; $display("FAIL tmo_reload: got %b want 1", Unlocked);
        end
        tick();
        checks++;
        if (Unlocked !== 1'b0) begin
            errors++; $display("FAIL tmo_expire: got %b want 0", Unlocked);
        end
        doWrite(8'd8, 8'h44);
        checks++;
        if (RegOut[71:64] !== 8'h33 || WrPulse !== 32'd0) begin
            errors++; $display("FAIL tmo_reject: reg %h pulse %h want 33/0", RegOut[71:64], WrPulse);
        end
`endif
    endtask

    task automatic test_key_abort();
`ifdef LPC_REG_LOCK_EN
        doWrite(8'hFF, 8'h5A);
        doWrite(8'd3, 8'h77);
        checks++;
        if (RegOut[31:24] !== 8'h77 || WrPulse !== 32'h8) begin
            errors++; $display("FAIL abort_midwrite: reg %h pulse %h want 77/8", RegOut[31:24], WrPulse);
        end
        doWrite(8'hFF, 8'hA5);
        tick();
        checks++;
        if (Unlocked !== 1'b0) begin
            errors++; $display("FAIL abort_locked: got %b want 0", Unlocked);
        end
        doWrite(8'hFF, 8'h5A);
        PciReset = 1'b0; #2;
        PciReset = 1'b1;
        tick();
        doWrite(8'hFF, 8'hA5);
        tick();
        checks++;
        if (Unlocked !== 1'b0) begin
            errors++; $display("FAIL abort_reset_key1: got %b want 0", Unlocked);
        end
`endif
        // Reset drops a pending write strobe immediately
        doWrite(8'd6, 8'h05);
        checks++;
        if (WrPulse !== 32'h40) begin
            errors++; $display("FAIL rst_pulse_pre: got %h want 40", WrPulse);
        end
        PciReset = 1'b0; #1;
        checks++;
        if (WrPulse !== 32'd0 || RegOut[55:48] !== 8'h00 || RegOut[15:8] !== 8'h55) begin
            errors++; $display("FAIL rst_abort: pulse %h reg6 %h reg1 %h want 0/00/55",
                               WrPulse, RegOut[55:48], RegOut[15:8]);
        end
        PciReset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_wr_mask();
        test_back_to_back();
        test_w1c();
        test_hw();
        test_lock();
        test_timeout();
        test_key_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpc_reg_bank.md
# lpc_reg_bank

Parametrised LPC-side configuration/status register bank, sitting behind the LPC I/O decoder in the Lpc hierarchy and clocked by the 33 MHz LPC clock. Each register bit is independently typed: plain software R/W, hardware-driven, or sticky write-1-to-clear event. Protected registers sit behind a key-sequence write lock with an inactivity timeout. The bank provides a per-register write-strobe pulse to downstream consumers such as the watchdog and power sequencing logic.

## Interface
- NUM_REGS, 32: number of 8-bit registers, legal 2..64; addresses 0..NUM_REGS-1
- RESET_VAL, all 8'h00: [NUM_REGS*8-1:0], reset value of register n at bits [8n+7:8n]
- WR_MASK, all 8'hFF: software-writable bits
- HW_MASK, all 8'h00: bits loaded every cycle from HwData
- W1C_MASK, all 8'h00: sticky bits, set by HwSet, cleared by SW writing 1
- LOCK_MASK, NUM_REGS'b0: bit n=1 makes register n write-protected
- KEY_ADDR, 8'hFF: lock key address; must be >= NUM_REGS
- UNLOCK_TMO, 1024: LpcClock cycles without an accepted write before auto-relock, 2..65535
- LpcClock  in  1  33 MHz LPC clock; all state on rising edge
- PciReset  in  1  asynchronous, active-low reset
- Addr  in  8  register address
- Wr  in  1  write strobe; each high cycle is one write
- DataWrSW  in  8  write data
- HwData  in  NUM_REGS*8  hardware values for HW_MASK bits
- HwSet  in  NUM_REGS*8  set pulses for W1C_MASK bits
- DataRd  out  8  combinational read data for Addr
- RegOut  out  NUM_REGS*8  all register contents, flat
- WrPulse  out  NUM_REGS  one-cycle pulse per accepted write
- Unlocked  out  1  lock state, 1 = protected registers writable

## Operation
- Mask precedence per bit: HW_MASK > W1C_MASK > WR_MASK; overlapping masks resolve by this order; bits in none are read-only and hold their reset value.
- HW bit: next = HwData bit, every cycle, regardless of Wr.
- W1C bit: next = (cur & ~(sw_clr)) | HwSet bit. sw_clr = accepted write to that register with the data bit at 1 and WR_MASK at 1. Simultaneous set and clear gives 1, so set wins.
- RW bit: next = DataWrSW bit on an accepted write to that register, otherwise it holds.
- Accepted write: Wr=1, Addr<NUM_REGS, and (LOCK_MASK[Addr]=0 or Unlocked=1). Writes to Addr>=NUM_REGS other than KEY_ADDR are ignored.
- DataRd:
  - RegOut[Addr] when Addr<NUM_REGS.
  - {7'b0,Unlocked} when Addr=KEY_ADDR.
  - 8'h00 otherwise.
- Lock FSM has 3 states: LOCKED, KEY1, UNLOCKED.
  - Reset state is LOCKED.
  - LOCKED: a write of 8'h5A to KEY_ADDR moves to KEY1; all other writes leave it in LOCKED.
  - KEY1: the next write of 8'hA5 to KEY_ADDR moves to UNLOCKED. Any other write moves to LOCKED, and that write is rejected if its register is protected. Timer expiry moves to LOCKED.
  - UNLOCKED: any write to KEY_ADDR moves to LOCKED. Timer expiry moves to LOCKED.
- Timer: loaded with UNLOCK_TMO-1 on entry to KEY1/UNLOCKED and on every accepted write. It decrements each idle cycle. Expiry is the count at 0 with no write that cycle. A write in the expiry cycle is accepted and reloads the timer.

## Timing
- Reset: registers = RESET_VAL, WrPulse = 0, Unlocked = 0, FSM = LOCKED, timer = 0.
- A write at edge N is visible on RegOut/DataRd after edge N. WrPulse[n] is high for the cycle following edge N, exactly one cycle per accepted write; back-to-back writes give back-to-back pulses.
- HwData/HwSet are sampled at each edge, giving 1-cycle latency to RegOut.
- Unlocked asserts the cycle after the 8'hA5 write. A protected-register write in that following cycle is accepted.
- Reset assertion mid-sequence aborts immediately to LOCKED. It also clears any pending WrPulse.

## Configuration
- LPC_REG_LOCK_EN defined: the lock FSM, timer and KEY_ADDR decode are built.
- LPC_REG_LOCK_EN undefined:
  - LOCK_MASK is ignored and all registers are always writable.
  - Unlocked is tied to 1.
  - KEY_ADDR reads 8'h00 and writes to it are ignored.
  - No timer flops are built.

## Structure
- Package lpc_reg_pkg holds:
  - the lock state enum
  - LPC_KEY1 = 8'h5A and LPC_KEY2 = 8'hA5
  - REG_W = 8
  - a clog2-based timer-width function
- Sub-module lpc_reg_lock contains the FSM and timer. Its inputs are Wr, Addr and DataWrSW; its output is Unlocked. It is instantiated only under LPC_REG_LOCK_EN.
- The register array is a generate loop over NUM_REGS with per-bit mask logic.

## Test plan
- Reset with NUM_REGS=32, RESET_VAL reg1=8'h55 -> DataRd at Addr 1 = 8'h55, Unlocked=0, WrPulse=0.
- WR_MASK reg4=8'h1B, write 8'hFF to Addr 4 from 8'h00 -> reg4=8'h1B, WrPulse[4] high 1 cycle.
- W1C bit0 of reg2 set by a HwSet pulse, then write 8'h01 with HwSet held high the same cycle -> bit stays 1. Write 8'h01 with HwSet low -> 0.
- LOCK_MASK reg8, write 8'hAA while LOCKED -> reg8 unchanged, no WrPulse. Then key 5A, A5 at KEY_ADDR, write 8'hAA -> reg8=8'hAA, DataRd at KEY_ADDR = 8'h01.
- Unlock with UNLOCK_TMO=16, then idle 16 cycles -> Unlocked=0 and a write to reg8 is rejected. A write at cycle 15 keeps it unlocked.
- Key 5A, then write to Addr 3, then A5 -> stays LOCKED. PciReset pulsed in KEY1 -> LOCKED.
